// File: rtl/bf_host.sv
// bf_host: rewinds, loads and runs a Boolfuck program on the interpreter's button/key port.
// Optional run-stall watchdog with sticky tmo output: define BF_HOST_RUN_TIMEOUT_EN.
module bf_host #(
  parameter int C       = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [7:0]   src_data,
  input  logic         src_last,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         lft,
  output logic         rgt,
  output logic         ctl,
  output logic [7:0]   key,
  input  logic [1:0]   blk,
  input  logic [C-1:0] icur,
  input  logic         obit,
  output logic         busy,
  output logic         done,
`ifdef BF_HOST_RUN_TIMEOUT_EN
  output logic         tmo,
`endif
  output logic         ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_LOAD, S_HALT, S_GO, S_RUN, S_DONE
  } state_t;

  state_t         r_state, w_state;
  logic           r_lft, r_rgt, r_ctl;
  logic           w_lft, w_rgt, w_ctl;
  logic [7:0]     r_key, w_key, w_code;
  logic [C-1:0]   r_cnt, w_cnt;
  logic           r_ovf, w_ovf;
  logic           r_ov, w_ov;
  logic           r_ob, w_ob;
  logic           w_pulse;

`ifdef BF_HOST_RUN_TIMEOUT_EN
  logic [15:0]    r_tcnt, w_tcnt;
  logic [1:0]     r_blk;
  logic           r_tmo, w_tmo;
`else
  logic           w_unused;
  assign w_unused = ^TIMEOUT;
`endif

  function automatic logic [7:0] f_map(input logic [7:0] d);
    case (d)
      8'h2B:   return 8'h02;
      8'h3C:   return 8'h04;
      8'h3E:   return 8'h08;
      8'h3B:   return 8'h10;
      8'h2C:   return 8'h20;
      8'h5B:   return 8'h40;
      8'h5D:   return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // Decisions are taken only in cycles with no pulse out, which yields the gap.
  assign w_pulse = r_lft | r_rgt | r_ctl | (|r_key);

  always_comb begin
    w_state = r_state;
    w_lft   = 1'b0;
    w_rgt   = 1'b0;
    w_ctl   = 1'b0;
    w_key   = 8'h00;
    w_cnt   = r_cnt;
    w_ovf   = r_ovf;
    w_ov    = r_ov;
    w_ob    = r_ob;
    w_code  = f_map(src_data);
`ifdef BF_HOST_RUN_TIMEOUT_EN
    w_tmo   = r_tmo;
    w_tcnt  = r_tcnt;
    if (r_state == S_RUN && blk == 2'b00)
      w_tcnt = r_tcnt + 16'd1;
    if (r_state == S_GO || blk != r_blk)
      w_tcnt = '0;
`endif
    if (r_state == S_DONE) begin
      w_state = S_IDLE;
    end else if (!w_pulse) begin
      unique case (r_state)
        S_IDLE: begin
          if (src_valid) begin
            w_ctl   = (blk != 2'b11);
            w_state = S_REWIND;
`ifdef BF_HOST_RUN_TIMEOUT_EN
            w_tmo   = 1'b0;
`endif
          end
        end
        S_REWIND: begin
          if (icur != '0) begin
            w_rgt = icur[C-1];
            w_lft = ~icur[C-1];
          end else begin
            w_state = S_LOAD;
            w_cnt   = '0;
            w_ovf   = 1'b0;
          end
        end
        S_LOAD: begin
          if (src_valid) begin
            if (w_code != 8'h00) begin
              if (r_cnt == {C{1'b1}}) begin
                w_ovf = 1'b1;
              end else begin
                w_key = w_code;
                w_cnt = r_cnt + 1'b1;
              end
            end
            if (src_last)
              w_state = S_HALT;
          end
        end
        S_HALT: begin
          w_key   = 8'h01;
          w_state = S_GO;
        end
        S_GO: begin
          w_ctl   = 1'b1;
          w_state = S_RUN;
        end
        S_RUN: begin
          unique case (blk)
            2'b01: begin
              if (r_ov) begin
                if (out_ready) begin
                  w_ov  = 1'b0;
                  w_key = 8'h01;
                end
              end else begin
                w_ov = 1'b1;
                w_ob = obit;
              end
            end
            2'b10: begin
              if (in_valid)
                w_key = in_bit ? 8'h02 : 8'h01;
            end
            2'b11: w_state = S_DONE;
            default: begin
`ifdef BF_HOST_RUN_TIMEOUT_EN
              if (r_tcnt == 16'(TIMEOUT)) begin
                w_ctl   = 1'b1;
                w_tmo   = 1'b1;
                w_state = S_DONE;
              end
`endif
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lft   <= 1'b0;
      r_rgt   <= 1'b0;
      r_ctl   <= 1'b0;
      r_key   <= 8'h00;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_ov    <= 1'b0;
      r_ob    <= 1'b0;
`ifdef BF_HOST_RUN_TIMEOUT_EN
      r_tcnt  <= '0;
      r_blk   <= 2'b11;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_lft   <= w_lft;
      r_rgt   <= w_rgt;
      r_ctl   <= w_ctl;
      r_key   <= w_key;
      r_cnt   <= w_cnt;
      r_ovf   <= w_ovf;
      r_ov    <= w_ov;
      r_ob    <= w_ob;
`ifdef BF_HOST_RUN_TIMEOUT_EN
      r_tcnt  <= w_tcnt;
      r_blk   <= blk;
      r_tmo   <= w_tmo;
`endif
    end
  end

  assign lft       = r_lft;
  assign rgt       = r_rgt;
  assign ctl       = r_ctl;
  assign key       = r_key;
  assign src_ready = (r_state == S_LOAD) && !w_pulse;
  assign in_ready  = (r_state == S_RUN) && !w_pulse && (blk == 2'b10);
  assign out_valid = r_ov;
  assign out_bit   = r_ob;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign ovf       = r_ovf;
`ifdef BF_HOST_RUN_TIMEOUT_EN
  assign tmo       = r_tmo;
`endif

endmodule

// File: tb/tb_bf_host.sv
// tb_bf_host: bf_host against a cycle-level Boolfuck interpreter model, with
// every session checked against a string-level reference of the expected pulses.
`timescale 1ns/1ps
module tb_bf_host;
  localparam int C    = 8;
  localparam int EV_L = 1000;
  localparam int EV_R = 1001;
  localparam int EV_C = 1002;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic [7:0]   src_data = 8'h00;
  logic         src_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_bit = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_bit;
  logic         lft, rgt, ctl;
  logic [7:0]   key;
  logic [1:0]   blk = 2'b11;
  logic [C-1:0] icur = '0;
  logic         obit = 1'b0;
  logic         busy, done, ovf;
`ifdef BF_HOST_RUN_TIMEOUT_EN
  logic         tmo;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf_host #(.C(C)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .src_last(src_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .lft(lft), .rgt(rgt), .ctl(ctl), .key(key),
    .blk(blk), .icur(icur), .obit(obit),
    .busy(busy), .done(done),
`ifdef BF_HOST_RUN_TIMEOUT_EN
    .tmo(tmo),
`endif
    .ovf(ovf)
  );

  // ---------------- interpreter model ----------------
  logic [7:0] m_prog [256] = '{default: 8'h00};
  logic       m_mem  [256] = '{default: 1'b0};
  logic [7:0] m_pc  = 8'h00;
  logic [7:0] m_ptr = 8'h00;
  int         req_id = 0, seen_id = 0, req_icur = 0;
  bit         req_stall = 1'b0;

  function automatic logic [7:0] jump(input logic [7:0] pc);
    int   d;
    logic fwd;
    fwd = (m_prog[pc] == 8'h40);
    if (fwd == m_mem[m_ptr]) return pc + 8'd1;
    d = 1;
    for (int i = 0; i < 256 && d > 0; i++) begin
      pc = fwd ? pc + 8'd1 : pc - 8'd1;
      if (m_prog[pc] == (fwd ? 8'h40 : 8'h80)) d++;
      else if (m_prog[pc] == (fwd ? 8'h80 : 8'h40)) d--;
    end
    return pc + 8'd1;
  endfunction

  always @(posedge clk) begin
    if (req_id != seen_id) begin
      seen_id = req_id;
      if (req_stall) begin
        m_prog[0] = 8'h02;
        m_prog[1] = 8'h40;
        m_prog[2] = 8'h80;
        m_pc = 0; m_ptr = 0;
        m_mem = '{default: 1'b0};
        blk <= 2'b00;
      end else begin
        icur <= req_icur[C-1:0];
      end
    end else if (ctl) begin
      if (blk == 2'b11) begin
        blk <= 2'b00;
        m_pc = 0; m_ptr = 0;
        m_mem = '{default: 1'b0};
      end else begin
        blk <= 2'b11;
      end
    end else if (blk == 2'b11) begin
      if (lft) icur <= icur - 1'b1;
      else if (rgt) icur <= icur + 1'b1;
      else if (key != 8'h00) begin
        m_prog[icur] = key;
        icur <= icur + 1'b1;
      end
    end else if (blk == 2'b01) begin
      if (key == 8'h01) begin blk <= 2'b00; m_pc++; end
    end else if (blk == 2'b10) begin
      if (key != 8'h00) begin
        m_mem[m_ptr] = ~key[0];
        blk <= 2'b00;
        m_pc++;
      end
    end else begin
      case (m_prog[m_pc])
        8'h02: begin m_mem[m_ptr] = ~m_mem[m_ptr]; m_pc++; end
        8'h04: begin m_ptr--; m_pc++; end
        8'h08: begin m_ptr++; m_pc++; end
        8'h10: begin obit <= m_mem[m_ptr]; blk <= 2'b01; end
        8'h20: blk <= 2'b10;
        8'h40, 8'h80: m_pc = jump(m_pc);
        default: blk <= 2'b11;
      endcase
    end
  end

  // ---------------- reference and checking ----------------
  string      cmds  = "+<>;,[]";
  string      alpha = "+<>;,a \n";
  logic [7:0] stim[$];
  logic [7:0] src_q[$];
  int         exp_ev[$], got_ev[$];
  bit         exp_out[$], got_out[$], ins_q[$];
  int         prev_n = 0;

  function automatic logic [7:0] code_of(input logic [7:0] b);
    for (int i = 0; i < 7; i++)
      if (cmds[i] == b) return 8'(1 << (i + 1));
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic set_icur(input int v);
    @(negedge clk);
    req_stall = 1'b0; req_icur = v; req_id++;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_stall();
    @(negedge clk);
    req_stall = 1'b1; req_id++;
    repeat (4) @(negedge clk);
  endtask

  // force_in: -1 random input bits, otherwise every input bit takes that value
  task automatic session(input string name, input int n_extra,
                         input int abort_at, input int force_in);
    int         lastidx, consumed, v0, n, p, mis;
    bit         saw_busy, fin, ovf_e, b;
    logic [1:0] b0;
    logic [7:0] c;
    logic [7:0] codes[$];
    bit         m[256];
    lastidx = stim.size() - 1 - n_extra;
    b0 = blk;
    v0 = int'(icur);
    exp_ev.delete(); got_ev.delete();
    exp_out.delete(); got_out.delete(); ins_q.delete();
    if (b0 != 2'b11) exp_ev.push_back(EV_C);
    repeat (v0 >= 128 ? 256 - v0 : v0)
      exp_ev.push_back(v0 >= 128 ? EV_R : EV_L);
    ovf_e = 1'b0;
    for (int i = 0; i <= lastidx; i++) begin
      c = code_of(stim[i]);
      if (c != 8'h00) begin
        if (codes.size() < 255) codes.push_back(c);
        else ovf_e = 1'b1;
      end
    end
    foreach (codes[i]) exp_ev.push_back(int'(codes[i]));
    exp_ev.push_back(1);
    exp_ev.push_back(EV_C);
    p = 0;
    m = '{default: 1'b0};
    foreach (codes[i]) begin
      case (codes[i])
        8'h02: m[p] = ~m[p];
        8'h04: p = (p + 255) % 256;
        8'h08: p = (p + 1) % 256;
        8'h10: begin exp_out.push_back(m[p]); exp_ev.push_back(1); end
        8'h20: begin
          b = (force_in < 0) ? 1'($urandom_range(1, 0)) : 1'(force_in);
          ins_q.push_back(b);
          m[p] = b;
          exp_ev.push_back(b ? 2 : 1);
        end
        default: ;
      endcase
    end
    src_q = stim;
    consumed = 0; saw_busy = 0; fin = 0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge clk);
      src_valid = (src_q.size() > 0) && ($urandom_range(3, 0) != 0);
      src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      src_last  = (consumed == lastidx);
      in_valid  = (ins_q.size() > 0) && ($urandom_range(2, 0) != 0);
      in_bit    = (ins_q.size() > 0) ? ins_q[0] : 1'b0;
      out_ready = ($urandom_range(2, 0) != 0);
      #1;
      n = int'(lft) + int'(rgt) + int'(ctl) + int'(key != 8'h00);
      if (n > 0) begin
        check($sformatf("%s pulse_gap", name), 32'(prev_n * 16 + n), 32'h1);
        got_ev.push_back(lft ? EV_L : rgt ? EV_R : ctl ? EV_C : int'(key));
      end
      prev_n = n;
      if (src_valid && src_ready) begin
        void'(src_q.pop_front());
        consumed++;
      end
      if (in_valid && in_ready) void'(ins_q.pop_front());
      if (out_valid && out_ready) got_out.push_back(out_bit);
      if (busy) saw_busy = 1'b1;
      if (abort_at > 0 && got_ev.size() >= abort_at) begin
        rst = 1'b1;
        src_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check({name, " rst_pulses"}, {lft, rgt, ctl, key}, 0);
        check({name, " rst_busy"}, {busy, src_ready, done}, 0);
        rst = 1'b0;
        prev_n = 0;
        stim.delete();
        return;
      end
      if (done) begin
        fin = 1'b1;
        check({name, " busy_at_done"}, busy, 0);
      end
    end
    src_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check({name, " done_seen"}, fin, 1);
    check({name, " busy_seen"}, saw_busy, 1);
    check({name, " ev_count"}, got_ev.size(), exp_ev.size());
    mis = -1;
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      if (mis < 0 && got_ev[i] != exp_ev[i]) mis = i;
    if (mis >= 0)
      $display("%s: event %0d got %0d want %0d", name, mis,
               got_ev[mis], exp_ev[mis]);
    check({name, " ev_first_diff"}, mis, -1);
    check({name, " out_count"}, got_out.size(), exp_out.size());
    mis = -1;
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
      if (mis < 0 && got_out[i] != exp_out[i]) mis = i;
    check({name, " out_first_diff"}, mis, -1);
    check({name, " ovf"}, ovf, ovf_e);
    check({name, " src_left"}, src_q.size(), n_extra);
    check({name, " ins_left"}, ins_q.size(), 0);
    stim.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          {lft, rgt, ctl, key, src_ready, in_ready, out_valid, out_bit,
           busy, done, ovf}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    add_str("+;");
    session("basic", 0, 0, -1);

    set_icur(250);
    add_str("+>;<;");
    session("rewind_rgt", 0, 0, -1);

    set_icur(3);
    add_str("a +\n>");
    session("filter_lft", 0, 0, -1);

    set_stall();
    add_str(",;");
    session("stop_first", 0, 0, 0);

    repeat (300) stim.push_back(8'h2B);
    session("overflow", 0, 0, -1);

    for (int k = 0; k < 6; k++) begin
      int len, ex;
      len = $urandom_range(20, 1);
      ex  = $urandom_range(1, 0);
      for (int i = 0; i < len + ex; i++)
        stim.push_back(alpha[$urandom_range(alpha.len() - 1, 0)]);
      session($sformatf("rand%0d", k), ex, 0, -1);
    end

    set_icur(0);
    repeat (10) stim.push_back(8'h2B);
    session("abort", 0, 3, -1);
    repeat (2) @(negedge clk);

    add_str(";+;,;");
    stim.push_back(8'h3E);
    session("after_abort", 1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_host.md
Name: bf_host

Overview:
- Host-side controller that drives the Boolfuck interpreter's button/key interface from streams.
- Rewinds the interpreter's edit cursor, loads an ASCII program as key pulses, appends a halt and pulses ctl to run.
- During the run it serves input/output blocking states from bit streams.
- Sits between a byte source (UART/ROM) and the interpreter; its lft/rgt/ctl/key outputs wire straight to the interpreter's inputs.

Parameters:
- C, 8, interpreter program address width (program depth 2**C).
- TIMEOUT, 65535, run-stall limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_valid/src_ready/src_data/src_last  in/out/in/in  1/1/8/1  ASCII program stream; src_last marks the final byte
- in_valid/in_ready/in_bit  in/out/in  1/1/1  program input bit stream
- out_valid/out_ready/out_bit  out/in/out  1/1/1  program output bit stream
- lft, rgt, ctl  out  1 each  interpreter button pulses
- key  out  8  interpreter one-hot key pulses
- blk  in  2  interpreter block state (11 edit, 00 run, 01 output wait, 10 input wait)
- icur  in  C  interpreter edit cursor
- obit  in  1  interpreter mem[ptr]
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- ovf  out  1  sticky: program truncated

Behaviour:
- Reset: lft=rgt=ctl=0, key=0, src_ready=in_ready=out_valid=0, out_bit=0, busy=done=ovf=0; state IDLE; opcode count=0. Reset mid-session abandons it and drops pulses the same cycle; interpreter state is left as is.
- Pulse rule: every button/key action is exactly 1 cycle high, then at least 1 cycle all-low (GAP). No two outputs are ever high in the same cycle. blk/icur are evaluated only in GAP or later.
- IDLE: when src_valid=1:
  - blk!=11: pulse ctl (stop), then go to REWIND.
  - blk==11: go directly to REWIND.
  - busy=1 from that cycle on.
- REWIND: while icur!=0, pulse rgt if icur[C-1]=1, else pulse lft (shortest wrap direction). When icur==0, go to LOAD and clear ovf and count.
- LOAD: src_ready=1 for one cycle per byte. Mapping:
  - '+'→8'h02, '<'→8'h04, '>'→8'h08, ';'→8'h10, ','→8'h20, '['→8'h40, ']'→8'h80.
  - Any other byte is consumed without a pulse.
  - Each mapped byte pulses key and increments count.
  - If count==2**C-1, further command bytes are consumed without pulse and set ovf.
  - After the src_last byte: pulse key=8'h01 (halt) at the current slot, then pulse ctl → RUN.
- RUN (sampled after GAP):
  - blk==00: wait.
  - blk==01: out_bit<=obit, out_valid=1 held until out_ready; on handshake out_valid=0, pulse key=8'h01 (ack).
  - blk==10: in_ready=1; on in_valid&in_ready pulse key=8'h02 if in_bit=1, else key=8'h01 (interpreter stores ~key[0]).
  - blk==11: → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE. src bytes beyond src_last stay unconsumed until the next session.
- src_valid low in LOAD: stall with no pulses. Back-pressure on out/in streams stalls indefinitely.

Optional Feature:
- Macro BF_HOST_RUN_TIMEOUT_EN.
- Defined: a 16-bit counter clears on every RUN entry and on every blk change, and increments while blk==00. At TIMEOUT it pulses ctl (forces the interpreter to edit mode), sets sticky output port tmo (1 bit, cleared on next session start), then goes to DONE.
- Undefined: no counter, no tmo port; RUN waits forever.

Test Plan:
- Interpreter reset (blk=11, icur=0); stream "+;" with last → key pulses 02,10,01 then ctl; out_bit=1 handshake, key 01 ack, halt; done pulse; ovf=0.
- icur=250 at start (C=8) → 6 rgt pulses, no lft, before the first key pulse; icur=3 → 3 lft pulses.
- blk=00 at session start → ctl pulse first, then rewind/load; program ",;" with in_bit=0 → key 01 input, out_bit=0.
- Program "a +\n>" → only keys 02,08 plus halt 01; 'a', ' ', '\n' consumed with no pulse; verify 1-cycle gap between every pulse.
- 300 '+' bytes with C=8 → exactly 255 key 02 pulses, halt at slot 255, ovf=1.
- Reset asserted mid-LOAD → all pulses low next edge, busy=0; with BF_HOST_RUN_TIMEOUT_EN and TIMEOUT=100, program "+[]" → ctl pulse after 100 stalled cycles, tmo=1, done.
